piso_serializer: RTL and testbench

- Parallel-in serial-out transmitter; the sending end of the accelerator's serial word link.
- Accepts an N-bit word through a valid/ready handshake and shifts it out MSB first, one bit per enabled cycle.
- Its sout/sout_valid pair drives the receiving shift register's serial input and enable.
- Bit order is chosen so the receiver reassembles the word with the same bit positions as data_in.

---
 rtl/piso_serializer.sv | 129 ++++++++++++
 tb/tb_piso_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter for the serial word link.
// Accepts an N-bit word via valid/ready and shifts it out MSB first, one bit
// per non-stalled cycle. sout/sout_valid feed the receiver's serial input and
// enable.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the
// data bits. That bit then carries sout_last instead of the final data bit.
module piso_serializer #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         stall,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N) + 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sout_q, sout_d;
  logic           sout_valid_q, sout_valid_d;
  logic           sout_last_q, sout_last_d;
  logic           busy_q, busy_d;
`ifdef PISO_PARITY_EN
  logic           par_q, par_d;
`endif

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // Next-state decode: load in IDLE, shift one bit per non-stalled cycle.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    sout_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (!stall) begin
          sout_d       = shreg_q[N-1];
          sout_valid_d = 1'b1;
          shreg_d      = {shreg_q[N-2:0], 1'b0};
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
`ifdef PISO_PARITY_EN
            state_d     = PAR;
`else
            sout_last_d = 1'b1;
            state_d     = IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (!stall) begin
          sout_d       = par_q;
          sout_valid_d = 1'b1;
          sout_last_d  = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // The state returns to IDLE at the same edge that emits the final bit.
    // busy therefore also covers that final valid bit.
    busy_d = (state_d != IDLE) | sout_valid_d;
  end

  assign load_ready = (state_q == IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at N=8, default or PISO_PARITY_EN build.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       stall = 1'b0;
  logic       sout, sout_valid, sout_last, busy;

  int n_checks = 0;
  int n_errors = 0;

  piso_serializer #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .stall      (stall),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one word off the wire. expb holds the expected data bits, MSB sent
  // first. expp is the expected parity bit. Stall is held for cycles
  // slo..shi after the accept edge.
  task automatic emit_bits(input logic [7:0] expb, input logic expp, input int slo,
                           input int shi, input int exp_cycles, input string nm);
    int   idx = 0;
    int   k = 0;
    logic prev = 1'b0;
    logic e;
    while (idx < NB && k < 40) begin
      k++;
      stall = (k >= slo && k <= shi);
      tick();
      if (stall) begin
        check({nm, " stall valid"}, sout_valid, 1'b0);
        check({nm, " stall last"}, sout_last, 1'b0);
        if (idx > 0) check({nm, " stall hold"}, sout, prev);
      end else begin
        e = (idx < 8) ? expb[7 - idx] : expp;
        check($sformatf("%s bit%0d", nm, idx), sout, e);
        check($sformatf("%s valid%0d", nm, idx), sout_valid, 1'b1);
        check($sformatf("%s last%0d", nm, idx), sout_last, (idx == NB - 1));
        prev = e;
        idx++;
      end
    end
    stall = 1'b0;
    check({nm, " cycles"}, k, exp_cycles);
    check({nm, " ready@last"}, load_ready, 1'b1);
    check({nm, " busy@last"}, busy, 1'b1);
  endtask

  task automatic accept(input logic [7:0] w, input string nm);
    data_in    = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check({nm, " busy@acc"}, busy, 1'b1);
    check({nm, " ready@acc"}, load_ready, 1'b0);
    check({nm, " valid@acc"}, sout_valid, 1'b0);
  endtask

  task automatic expect_idle(input logic hold, input string nm);
    tick();
    check({nm, " idle valid"}, sout_valid, 1'b0);
    check({nm, " idle busy"}, busy, 1'b0);
    check({nm, " idle ready"}, load_ready, 1'b1);
    check({nm, " idle hold"}, sout, hold);
  endtask

  initial begin
    // Outputs are forced to their reset values while rst is high.
    #2;
    check("rst sout", sout, 1'b0);
    check("rst valid", sout_valid, 1'b0);
    check("rst ready", load_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle ready", load_ready, 1'b1);
    check("idle busy", busy, 1'b0);
    check("idle valid", sout_valid, 1'b0);
    check("idle sout", sout, 1'b0);
    check("idle last", sout_last, 1'b0);

    // Plain word A5; parity of A5 is 0.
    accept(8'hA5, "A5");
    emit_bits(8'b1010_0101, 1'b0, 0, -1, NB, "A5");
`ifdef PISO_PARITY_EN
    expect_idle(1'b0, "A5");
`else
    expect_idle(1'b1, "A5");
`endif

    // F0 with stall over cycles 3..5 after the accept edge.
    accept(8'hF0, "F0");
    emit_bits(8'b1111_0000, 1'b0, 3, 5, NB + 3, "F0");
    expect_idle(1'b0, "F0");

    // A load together with stall is accepted; a stall in the next cycle delays bit 0.
    data_in    = 8'h07;
    load_valid = 1'b1;
    stall      = 1'b1;
    tick();
    load_valid = 1'b0;
    check("07 busy@acc", busy, 1'b1);
    emit_bits(8'b0000_0111, 1'b1, 1, 1, NB + 1, "07");
`ifdef PISO_PARITY_EN
    expect_idle(1'b1, "07");
`else
    expect_idle(1'b1, "07");
`endif

    // An asynchronous reset after 3 bits aborts the word before the next edge.
    accept(8'hC3, "C3");
    tick();
    tick();
    tick();
    check("C3 3rd bit", sout, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst valid", sout_valid, 1'b0);
    check("arst sout", sout, 1'b0);
    check("arst busy", busy, 1'b0);
    check("arst ready", load_ready, 1'b1);
    check("arst last", sout_last, 1'b0);
    #1 rst = 1'b0;
    expect_idle(1'b0, "post-arst");
    accept(8'h3C, "3C");
    emit_bits(8'b0011_1100, 1'b0, 0, -1, NB, "3C");
    expect_idle(1'b0, "3C");

    // Back-to-back: load_valid stays high, so the words are separated by one gap cycle.
    data_in    = 8'h81;
    load_valid = 1'b1;
    tick();
    data_in    = 8'h7E;
    emit_bits(8'b1000_0001, 1'b0, 0, -1, NB, "81");
    tick();
    load_valid = 1'b0;
    check("b2b gap valid", sout_valid, 1'b0);
    check("b2b gap busy", busy, 1'b1);
    check("b2b gap ready", load_ready, 1'b0);
    emit_bits(8'b0111_1110, 1'b0, 0, -1, NB, "7E");
    expect_idle(1'b0, "7E");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
